instruction_fetch: RTL and testbench

Fetch unit that drives the program counter into the combinational instruction memory and captures the returned byte into an instruction register. It presents each instruction to the execute stage over a valid/ready handshake. It advances the PC by a fixed step on acceptance and redirects the PC on a branch. It also supports a level-sensitive halt.

---
 rtl/instruction_fetch_if.sv | 37 +++
 rtl/instruction_fetch.sv | 85 ++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus: instruction memory address/data, execute-stage handshake,
// branch redirect and halt control.
interface instruction_fetch_if;
    logic [7:0] pc_address;
    logic [7:0] instr_in;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ready;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       halt;
    logic       halted;

    modport master (
        output pc_address,
        output instr_out,
        output instr_valid,
        output halted,
        input  instr_in,
        input  instr_ready,
        input  branch_valid,
        input  branch_target,
        input  halt
    );

    modport slave (
        input  pc_address,
        input  instr_out,
        input  instr_valid,
        input  halted,
        output instr_in,
        output instr_ready,
        output branch_valid,
        output branch_target,
        output halt
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch unit: registered PC into combinational instruction memory, captured
// instruction presented over valid/ready, with branch redirect and halt.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] PC_STEP  = 8'd2
) (
    input logic           clk,
    input logic           rst_n,
    instruction_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] pc, pc_nxt;
    logic [7:0] ir, ir_nxt;
    logic       vld, vld_nxt;
    logic       hlt, hlt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= 8'h00;
            vld   <= 1'b0;
            hlt   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            vld   <= vld_nxt;
            hlt   <= hlt_nxt;
        end
    end

    // Branch outranks everything in both FETCH and HOLD; halt only gates capture.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        vld_nxt   = vld;
        hlt_nxt   = hlt;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.branch_valid) begin
                    pc_nxt = bus.branch_target;
                end else if (bus.halt) begin
                    hlt_nxt = 1'b1;
                end else begin
                    ir_nxt    = bus.instr_in;
                    vld_nxt   = 1'b1;
                    hlt_nxt   = 1'b0;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.branch_valid) begin
                    pc_nxt    = bus.branch_target;
                    vld_nxt   = 1'b0;
                    state_nxt = FETCH;
                end else if (vld && bus.instr_ready) begin
                    pc_nxt    = pc + PC_STEP;
                    vld_nxt   = 1'b0;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.pc_address  = pc;
    assign bus.instr_out   = ir;
    assign bus.instr_valid = vld;
    assign bus.halted      = hlt;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a transaction-level PC model queues
// the expected (pc, instruction) presentations; a monitor checks them.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch #(.RESET_PC(8'h00), .PC_STEP(8'd2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    assign bus.instr_in = mem[bus.pc_address];

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ins;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic [7:0] mpc;
    bit   idle;
    bit   seen;
    int   npres;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc  = mpc;
        e.ins = mem[mpc];
        exp_q.push_back(e);
    endtask

    // Asynchronous reset between edges; reset values must appear without a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        bus.instr_ready   = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        bus.halt          = 1'b0;
        #1;
        chk("rst_pc", bus.pc_address, 8'h00);
        chk("rst_instr", bus.instr_out, 8'h00);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_halted", bus.halted, 1'b0);
        @(negedge clk);
        exp_q.delete();
        mpc   = 8'h00;
        idle  = 1'b1;
        npres = 0;
        push_exp();
        rst_n = 1'b1;
    endtask

    // One cycle: apply inputs for the coming edge and advance the abstract PC.
    task automatic cyc(input logic r, input logic b, input logic [7:0] t, input logic h);
        bus.instr_ready   = r;
        bus.branch_valid  = b;
        bus.branch_target = t;
        bus.halt          = h;
        if (b && !idle) begin
            exp_q.delete();
            mpc = t;
            push_exp();
        end else if (bus.instr_valid && r) begin
            mpc = mpc + 8'd2;
            push_exp();
        end
        idle = 1'b0;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.instr_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %0h instr %0h expected none", bus.pc_address, bus.instr_out);
                end else begin
                    cur = exp_q.pop_front();
                    chk("mon_pc", bus.pc_address, cur.pc);
                    chk("mon_instr", bus.instr_out, cur.ins);
                    npres++;
                end
                seen = 1'b1;
            end else begin
                chk("hold_pc", bus.pc_address, cur.pc);
                chk("hold_instr", bus.instr_out, cur.ins);
            end
        end else begin
            seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0]     = 8'h00;
        mem[2]     = 8'hD3;
        mem[4]     = 8'h50;
        mem[6]     = 8'hD1;
        mem[8]     = 8'h51;
        mem[10]    = 8'h10;
        mem[8'hFE] = 8'hA5;

        // sequential fetch with ready tied high
        do_reset();
        repeat (12) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("seq_count", npres, 6);
        chk("seq_qempty", exp_q.size(), 0);

        // backpressure on D3
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_instr", bus.instr_out, 8'hD3);
            chk("bp_valid", bus.instr_valid, 1'b1);
            chk("bp_pc", bus.pc_address, 8'h02);
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("bp_accept_pc", bus.pc_address, 8'h04);

        // branch during HOLD beats a simultaneous accept
        do_reset();
        repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("br_held", bus.instr_out, 8'h50);
        cyc(1'b1, 1'b1, 8'h0A, 1'b0);
        chk("br_valid_drop", bus.instr_valid, 1'b0);
        chk("br_pc", bus.pc_address, 8'h0A);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("br_instr", bus.instr_out, 8'h10);
        chk("br_valid", bus.instr_valid, 1'b1);

        // wrap-around from 0xFE
        cyc(1'b0, 1'b1, 8'hFE, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("wrap_fe_instr", bus.instr_out, 8'hA5);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("wrap_pc", bus.pc_address, 8'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("wrap_instr", bus.instr_out, 8'h00);
        chk("wrap_valid", bus.instr_valid, 1'b1);

        // halt in FETCH at pc 6
        do_reset();
        repeat (7) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'h00, 1'b1);
            chk("halt_halted", bus.halted, 1'b1);
            chk("halt_valid", bus.instr_valid, 1'b0);
            chk("halt_pc", bus.pc_address, 8'h06);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("unhalt_instr", bus.instr_out, 8'hD1);
        chk("unhalt_halted", bus.halted, 1'b0);
        chk("unhalt_valid", bus.instr_valid, 1'b1);

        // reset mid-HOLD, then restart latency
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mid_pre_valid", bus.instr_valid, 1'b1);
        do_reset();
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("restart_e1_valid", bus.instr_valid, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("restart_e2_valid", bus.instr_valid, 1'b1);
        chk("restart_pc", bus.pc_address, 8'h00);
        chk("restart_instr", bus.instr_out, 8'h00);

        // randomized traffic
        do_reset();
        repeat (600) cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                         8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0));
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
